// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared constants and types for the add_seq_32 word-serial
// multi-precision adder controller.
//   WORD_W          - datapath word width (32)
//   add_seq_state_t - packet sequencing state (ST_FIRST / ST_CONT)
package add_seq_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_CONT  = 1'b1
  } add_seq_state_t;

endpackage

// File: rtl/add_seq_32_full_adder.sv
// full_adder_32bit: shared combinational 32-bit adder datapath.
// Ports:
//   A_i   [31:0] in   operand A
//   Y_i   [31:0] in   operand B (already inverted by the caller when subtracting)
//   C_i          in   carry-in
//   Sum_o [31:0] out  sum
//   c_o          out  carry-out of bit 31
module full_adder_32bit
  import add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] A_i,
  input  logic [WORD_W-1:0] Y_i,
  input  logic              C_i,
  output logic [WORD_W-1:0] Sum_o,
  output logic              c_o
);

  assign {c_o, Sum_o} = {1'b0, A_i} + {1'b0, Y_i} + {{WORD_W{1'b0}}, C_i};

endmodule

// File: rtl/add_seq_32.sv
// add_seq_32: word-serial multi-precision add controller. Operand words arrive
// LSW first on a valid/ready stream; each pair goes through one shared
// full_adder_32bit, the inter-word carry is held in carry_q, and the result
// word is presented from a registered output stage one cycle later.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; the producer holds its beat stable until it transfers, and the output
// stage holds all out_* stable while out_valid_o=1 and out_ready_i=0.
//
// Optional feature: define ADD_SEQ_SUB_EN to add in_sub_i (subtract request,
// sampled on the first beat of a packet).
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   in_valid_i / in_ready_o, in_a_i[31:0], in_b_i[31:0], in_cin_i, in_last_i,
//   in_sub_i (ADD_SEQ_SUB_EN only)
//   out_valid_o / out_ready_i, out_sum_o[31:0], out_last_o, out_cout_o,
//   out_ovf_o, out_err_o
//   busy_o - FSM state is ST_CONT (packet in progress)
module add_seq_32
  import add_seq_pkg::*;
#(
  parameter int MAX_WORDS = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_a_i,
  input  logic [WORD_W-1:0] in_b_i,
  input  logic              in_cin_i,
  input  logic              in_last_i,
`ifdef ADD_SEQ_SUB_EN
  input  logic              in_sub_i,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_sum_o,
  output logic              out_last_o,
  output logic              out_cout_o,
  output logic              out_ovf_o,
  output logic              out_err_o,
  output logic              busy_o
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  add_seq_state_t state_q, state_d;
  logic           carry_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_inc;
  logic           accept;
  logic           first;
  logic           sub_eff;
  logic [WORD_W-1:0] b_eff;
  logic           adder_cin;
  logic [WORD_W-1:0] adder_sum;
  logic           adder_cout;
  logic           reach_max;
  logic           last_eff;
  logic           ovf;

  assign first      = (state_q == ST_FIRST);
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = (state_q == ST_CONT);

`ifdef ADD_SEQ_SUB_EN
  logic sub_q;
  // The first beat uses the live request; later beats use the latched one.
  assign sub_eff = first ? in_sub_i : sub_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sub_q <= 1'b0;
    end else if (accept && first) begin
      sub_q <= in_sub_i;
    end
  end
`else
  assign sub_eff = 1'b0;
`endif

  // Subtraction is A + ~B + 1; on the first beat in_cin_i then acts as
  // borrow-in, hence the inversion of the packet carry-in.
  assign b_eff     = in_b_i ^ {WORD_W{sub_eff}};
  assign adder_cin = first ? (in_cin_i ^ sub_eff) : carry_q;

  full_adder_32bit u_adder (
    .A_i   (in_a_i),
    .Y_i   (b_eff),
    .C_i   (adder_cin),
    .Sum_o (adder_sum),
    .c_o   (adder_cout)
  );

  // A beat that fills the packet to MAX_WORDS closes it even without last.
  assign cnt_inc   = cnt_q + CW'(1);
  assign reach_max = (cnt_inc == MAX_CNT);
  assign last_eff  = in_last_i || reach_max;
  assign ovf       = (in_a_i[WORD_W-1] == b_eff[WORD_W-1]) &&
                     (adder_sum[WORD_W-1] != in_a_i[WORD_W-1]);

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = last_eff ? ST_FIRST : ST_CONT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      if (last_eff) begin
        carry_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        carry_q <= adder_cout;
        cnt_q   <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_sum_o   <= '0;
      out_last_o  <= 1'b0;
      out_cout_o  <= 1'b0;
      out_ovf_o   <= 1'b0;
      out_err_o   <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      out_sum_o   <= adder_sum;
      out_last_o  <= last_eff;
      out_cout_o  <= last_eff && adder_cout;
      out_ovf_o   <= last_eff && ovf;
      out_err_o   <= reach_max && !in_last_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
